// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a small byte FIFO so the host can queue bytes back-to-back.
// Latency: byte written at edge E into an empty FIFO while idle drives the start bit after edge E+1.
// Backpressure: o_TX_Ready (registered) drops when the FIFO is full; i_TX_DV while not ready is dropped.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous reset, active-low
//   i_TX_DV      write strobe, accepted when o_TX_Ready=1
//   i_TX_Byte    byte to queue, sampled with i_TX_DV
//   o_TX_Ready   FIFO not full
//   o_TX_Active  frame on the line (START through STOP)
//   o_TX_Serial  serial line, idles high
//   o_TX_Done    one-cycle pulse when a stop bit completes
//
// Optional: define UART_TX_PARITY_EN to insert an even parity bit between data and stop (8E1).
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t             state_q;
  logic [BAUD_W-1:0]  baud_q;
  logic [2:0]         bit_idx_q;
  logic [7:0]         shift_q;
  logic               serial_q;
  logic               active_q;
  logic               done_q;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic               ready_q;

  logic               wr_en;
  logic               pop;
  logic               baud_last;

  assign baud_last = (baud_q == BAUD_LAST);
  assign wr_en     = i_TX_DV & ready_q;

  // The FSM takes the head byte either from IDLE or straight out of the
  // final STOP cycle, which gives zero idle gap between queued frames.
  always_comb begin
    pop = 1'b0;
    if (count_q != '0) begin
      if (state_q == S_IDLE) begin
        pop = 1'b1;
      end else if ((state_q == S_STOP) && baud_last) begin
        pop = 1'b1;
      end
    end
  end

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= i_TX_Byte;
    end
  end

  // Ready is registered from the next count, so a write arriving on the
  // same edge as a pop from a full FIFO is still refused.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      count_q <= count_d;
      ready_q <= (count_d != CNT_FULL);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      baud_q    <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      serial_q  <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          serial_q <= 1'b1;
          baud_q   <= '0;
          if (pop) begin
            shift_q  <= mem_q[rd_ptr_q];
            state_q  <= S_START;
            serial_q <= 1'b0;
            active_q <= 1'b1;
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_q    <= '0;
            bit_idx_q <= '0;
            state_q   <= S_DATA;
            serial_q  <= shift_q[0];
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state_q  <= S_PARITY;
              serial_q <= ^shift_q;
`else
              state_q  <= S_STOP;
              serial_q <= 1'b1;
`endif
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              serial_q  <= shift_q[bit_idx_q + 3'd1];
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_last) begin
            baud_q   <= '0;
            state_q  <= S_STOP;
            serial_q <= 1'b1;
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (baud_last) begin
            baud_q <= '0;
            done_q <= 1'b1;
            if (pop) begin
              shift_q  <= mem_q[rd_ptr_q];
              state_q  <= S_START;
              serial_q <= 1'b0;
            end else begin
              state_q  <= S_IDLE;
              serial_q <= 1'b1;
              active_q <= 1'b0;
            end
          end else begin
            baud_q <= baud_q + BAUD_W'(1);
          end
        end
        default: begin
          state_q  <= S_IDLE;
          serial_q <= 1'b1;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign o_TX_Ready  = ready_q;
  assign o_TX_Active = active_q;
  assign o_TX_Serial = serial_q;
  assign o_TX_Done   = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
`timescale 1ns/1ps
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int FRAME_CYC = FRAME_BITS * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       i_TX_DV = 1'b0;
  logic [7:0] i_TX_Byte = 8'h00;
  logic       o_TX_Ready;
  logic       o_TX_Active;
  logic       o_TX_Serial;
  logic       o_TX_Done;

  int checks = 0;
  int failures = 0;
  logic [7:0] sb_q[$];
  bit mon_en = 1'b0;
  int done_total = 0;
  int frames_seen = 0;

  // Single-byte vectors: byte, expected line samples in transmit order
  // (start, data LSB first, stop), expected even parity bit.
  typedef struct {
    logic [7:0] din;
    logic [9:0] line;
    logic       par;
  } vec_t;
  vec_t vecs[5];

  typedef struct {
    logic [7:0] din;
    logic       exp_rdy;
  } ovf_t;
  ovf_t ovf[6];

  logic [7:0] b2b[4];
  int dcyc[$];

  always #5 clk = ~clk;

  uart_tx_fifo #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_TX_DV(i_TX_DV),
    .i_TX_Byte(i_TX_Byte),
    .o_TX_Ready(o_TX_Ready),
    .o_TX_Active(o_TX_Active),
    .o_TX_Serial(o_TX_Serial),
    .o_TX_Done(o_TX_Done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Line monitor: decodes each frame mid-bit and scores it against the queue.
  int mon_cyc = 0;
  bit mon_busy = 1'b0;
  logic [10:0] mon_bits = '0;

  task automatic score_frame();
    logic [7:0] exp_b;
    frames_seen++;
    check("sb_frame_expected", (sb_q.size() != 0), 1);
    if (sb_q.size() != 0) begin
      exp_b = sb_q.pop_front();
      check("sb_start_bit", mon_bits[0], 0);
      check("sb_data", mon_bits[8:1], exp_b);
`ifdef UART_TX_PARITY_EN
      check("sb_parity", mon_bits[9], ^exp_b);
`endif
      check("sb_stop_bit", mon_bits[FRAME_BITS-1], 1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst || !mon_en) begin
      mon_busy = 1'b0;
    end else begin
      if (!mon_busy && (o_TX_Serial == 1'b0)) begin
        mon_busy = 1'b1;
        mon_cyc = 0;
      end
      if (mon_busy) begin
        if ((mon_cyc % CPB) == (CPB / 2)) mon_bits[4'(mon_cyc / CPB)] = o_TX_Serial;
        mon_cyc++;
        if (mon_cyc == FRAME_CYC) begin
          mon_busy = 1'b0;
          score_frame();
        end
      end
    end
    if (rst && o_TX_Done) done_total++;
  end

  task automatic wait_idle(input int budget);
    int n;
    bit idle;
    n = 0;
    idle = 1'b0;
    while (!idle && n < budget) begin
      @(negedge clk);
      n++;
      idle = !o_TX_Active && (sb_q.size() == 0);
    end
    check("wait_idle_within_budget", idle, 1);
  endtask

  task automatic send_one(input vec_t v);
    logic [FRAME_BITS-1:0] exp;
    bit act_ok;
    for (int i = 0; i < 9; i++) exp[i] = v.line[9-i];
`ifdef UART_TX_PARITY_EN
    exp[9] = v.par;
`endif
    exp[FRAME_BITS-1] = v.line[0];
    @(negedge clk);
    check("ready_before_write", o_TX_Ready, 1);
    i_TX_DV = 1'b1;
    i_TX_Byte = v.din;
    sb_q.push_back(v.din);
    @(negedge clk);
    i_TX_DV = 1'b0;
    i_TX_Byte = ~v.din;
    check("line_high_after_write_edge", o_TX_Serial, 1);
    @(negedge clk);
    check("line_low_next_edge", o_TX_Serial, 0);
    act_ok = 1'b1;
    for (int c = 0; c < FRAME_CYC; c++) begin
      if (c > 0) @(negedge clk);
      if (!o_TX_Active || o_TX_Done) act_ok = 1'b0;
      if ((c % CPB) == (CPB / 2))
        check($sformatf("bit%0d_of_%02h", c / CPB, v.din), o_TX_Serial, exp[c / CPB]);
    end
    check("active_no_done_in_frame", act_ok, 1);
    @(negedge clk);
    check("done_at_frame_end", o_TX_Done, 1);
    check("active_low_after_frame", o_TX_Active, 0);
    @(negedge clk);
    check("done_one_cycle", o_TX_Done, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok_ser, ok_act, ok_done, ok_rdy, gap, ready_drop;
    int cyc, frames0, done0;

    vecs[0] = '{8'hA5, 10'b0_1010_0101_1, 1'b0};
    vecs[1] = '{8'h07, 10'b0_1110_0000_1, 1'b1};
    vecs[2] = '{8'h03, 10'b0_1100_0000_1, 1'b0};
    vecs[3] = '{8'h80, 10'b0_0000_0001_1, 1'b1};
    vecs[4] = '{8'h3C, 10'b0_0011_1100_1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      ovf[i].din = 8'(i + 1);
      ovf[i].exp_rdy = (i < 5);
    end
    b2b[0] = 8'h00; b2b[1] = 8'hFF; b2b[2] = 8'h55; b2b[3] = 8'h3C;

    // Reset and idle.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_serial", o_TX_Serial, 1);
    check("rst_active", o_TX_Active, 0);
    check("rst_done", o_TX_Done, 0);
    check("rst_ready", o_TX_Ready, 1);
    rst = 1'b1;
    ok_ser = 1; ok_act = 1; ok_done = 1; ok_rdy = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (o_TX_Serial !== 1'b1) ok_ser = 0;
      if (o_TX_Active !== 1'b0) ok_act = 0;
      if (o_TX_Done !== 1'b0) ok_done = 0;
      if (o_TX_Ready !== 1'b1) ok_rdy = 0;
    end
    check("idle_serial_high", ok_ser, 1);
    check("idle_active_low", ok_act, 1);
    check("idle_done_low", ok_done, 1);
    check("idle_ready_high", ok_rdy, 1);
    mon_en = 1'b1;

    // Single-byte frames from the vector table.
    for (int i = 0; i < 5; i++) send_one(vecs[i]);
    wait_idle(200);

    // Back-to-back writes: four contiguous frames, Done every frame length.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("b2b_ready", o_TX_Ready, 1);
      i_TX_DV = 1'b1;
      i_TX_Byte = b2b[i];
      sb_q.push_back(b2b[i]);
    end
    @(negedge clk);
    i_TX_DV = 1'b0;
    dcyc.delete();
    gap = 1'b0;
    ready_drop = 1'b0;
    cyc = 0;
    while (dcyc.size() < 4 && cyc < 400) begin
      if (o_TX_Done) dcyc.push_back(cyc);
      if (dcyc.size() < 4 && !o_TX_Active) gap = 1'b1;
      if (!o_TX_Ready) ready_drop = 1'b1;
      @(negedge clk);
      cyc++;
    end
    check("b2b_done_count", dcyc.size(), 4);
    check("b2b_no_idle_gap", gap, 0);
    check("b2b_ready_stayed_high", ready_drop, 0);
    for (int i = 0; i < 3; i++)
      if (dcyc.size() > i + 1) check("b2b_done_spacing", dcyc[i+1] - dcyc[i], FRAME_CYC);
    wait_idle(200);

    // Overflow: sixth byte arrives while full and is dropped.
    frames0 = frames_seen;
    done0 = done_total;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("ovf_ready_%0d", i), o_TX_Ready, ovf[i].exp_rdy);
      i_TX_DV = 1'b1;
      i_TX_Byte = ovf[i].din;
      if (ovf[i].exp_rdy) sb_q.push_back(ovf[i].din);
    end
    @(negedge clk);
    i_TX_DV = 1'b0;
    check("ovf_ready_after_drop", o_TX_Ready, 0);
    wait_idle(600);
    repeat (2 * FRAME_CYC) @(negedge clk);
    check("ovf_frames_on_line", frames_seen - frames0, 5);
    check("ovf_done_pulses", done_total - done0, 5);

    // Reset in the middle of data bit 3 of 0x0F.
    mon_en = 1'b0;
    @(negedge clk);
    i_TX_DV = 1'b1;
    i_TX_Byte = 8'h0F;
    @(negedge clk);
    i_TX_DV = 1'b0;
    @(negedge clk);
    check("rstmid_line_low", o_TX_Serial, 0);
    repeat (4 * CPB) @(negedge clk);
    check("rstmid_bit3_value", o_TX_Serial, 1);
    check("rstmid_active_before", o_TX_Active, 1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_serial", o_TX_Serial, 1);
    check("rstmid_active", o_TX_Active, 0);
    check("rstmid_done", o_TX_Done, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    ok_ser = 1; ok_act = 1; ok_done = 1; ok_rdy = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (o_TX_Serial !== 1'b1) ok_ser = 0;
      if (o_TX_Active !== 1'b0) ok_act = 0;
      if (o_TX_Done !== 1'b0) ok_done = 0;
      if (o_TX_Ready !== 1'b1) ok_rdy = 0;
    end
    check("post_rst_line_idle", ok_ser, 1);
    check("post_rst_inactive", ok_act, 1);
    check("post_rst_no_done", ok_done, 1);
    check("post_rst_fifo_empty", ok_rdy, 1);

    check("scoreboard_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- UART transmitter: serialises bytes into 8N1 frames (start bit, 8 data bits LSB first, stop bit).
- A small input FIFO lets the host queue bytes back-to-back.
- Pairs with the team's UART receiver on the same link and uses the same CLKS_PER_BIT convention.
- Sits between the smartwatch control logic and the board TX pin.

Parameters:
- CLKS_PER_BIT, 217, clock cycles per UART bit (25 MHz / 115200); legal range 2..65535.
- FIFO_DEPTH, 4, byte entries in the input FIFO; power of 2, minimum 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- i_TX_DV  input  1  write strobe; byte accepted on a rising edge where i_TX_DV=1 and o_TX_Ready=1.
- i_TX_Byte  input  8  byte to transmit; sampled with i_TX_DV.
- o_TX_Ready  output  1  FIFO not full.
- o_TX_Active  output  1  high while a frame is on the line (START through STOP).
- o_TX_Serial  output  1  serial line; idles high.
- o_TX_Done  output  1  one-cycle pulse after each frame's stop bit completes.

Behaviour:
- Reset (rst=0, asynchronous):
  - Outputs: o_TX_Serial=1, o_TX_Active=0, o_TX_Done=0, o_TX_Ready=1.
  - Internal: FIFO emptied, FSM to IDLE, bit counter and baud counter cleared.
  - Reset mid-frame aborts the frame; the line returns high immediately.
- Reset release: synchronous deassertion is handled outside the block; rst is consumed as-is.
- FIFO:
  - Write when i_TX_DV & o_TX_Ready.
  - i_TX_DV while full is ignored; the byte is dropped and no state changes.
  - Simultaneous write and pop when full: the pop frees the slot on that edge, but o_TX_Ready is registered, so the write is rejected.
  - Simultaneous write and pop when not full: both happen.
  - Pointers wrap modulo FIFO_DEPTH; a separate count distinguishes full from empty.
- FSM states: IDLE, START, DATA, STOP (PARITY added by the optional feature).
  - IDLE: o_TX_Serial=1. If FIFO non-empty, pop head into shift register, go to START.
  - Latency: byte written at edge E into an empty FIFO with FSM in IDLE → o_TX_Serial low after edge E+1.
  - START: o_TX_Serial=0 for CLKS_PER_BIT cycles, then DATA with bit index 0.
  - DATA: drive shift bit [index] for CLKS_PER_BIT cycles. Index 0..7; after index 7, go to STOP.
  - STOP: o_TX_Serial=1 for CLKS_PER_BIT cycles.
  - End of STOP: o_TX_Done pulses for exactly one cycle. If FIFO non-empty, pop and go directly to START (zero idle gap); otherwise go to IDLE.
- Baud counter: runs 0..CLKS_PER_BIT-1 and resets on each bit transition. Every bit is exactly CLKS_PER_BIT cycles.
- o_TX_Active=1 in all states except IDLE. It stays high across back-to-back frames.
- Data stability: the shift register is loaded only at pop, so i_TX_Byte changes have no effect on an in-flight frame.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP, lasting CLKS_PER_BIT cycles.
  - Drives even parity (XOR of the 8 data bits); frame becomes 8E1, 11 bits.
- Undefined:
  - No PARITY state and no parity logic; frame is 8N1, 10 bits.

Test Plan:
- Reset idle: CLKS_PER_BIT=4, hold rst=0 then release → o_TX_Serial=1, o_TX_Ready=1, o_TX_Active=0, o_TX_Done=0 for 20 cycles.
- Single byte 0xA5, CLKS_PER_BIT=4:
  - Line goes low 1 cycle after the write edge.
  - Samples every 4 cycles read 0, 1,0,1,0,0,1,0,1, 1 (start, LSB-first data, stop).
  - o_TX_Done pulses once, 40 cycles after the line falls; o_TX_Active is high for those 40 cycles.
- Back-to-back: write 0x00, 0xFF, 0x55, 0x3C on consecutive cycles →
  - o_TX_Ready stays 1 throughout, since the first byte is popped before the fourth write.
  - 4 contiguous frames with no idle cycle between stop bit and next start bit.
  - 4 Done pulses, 40 cycles apart.
- Overflow, FIFO_DEPTH=4: write 6 bytes 0x01..0x06 on consecutive cycles →
  - o_TX_Ready drops to 0 after 5 accepted bytes (one popped, four queued).
  - 0x06 is dropped; exactly 0x01..0x05 appear on the line.
- Reset mid-frame: assert rst=0 during DATA bit 3 of 0x0F →
  - o_TX_Serial=1 and o_TX_Active=0 in the same cycle, with no Done pulse.
  - After release, the FIFO is empty and the line stays idle.
- Parity (UART_TX_PARITY_EN defined): send 0x07 → parity bit=1 and frame is 44 cycles. Send 0x03 → parity bit=0.
